// File: rtl/if_fetch_stage.sv
// Instruction fetch stage for the dual-issue pipeline: owns the PC, fetches aligned
// instruction pairs from synchronous memory and drives the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int unsigned         PC_WIDTH   = 8,
  parameter int unsigned         INST_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCWrite,
  input  logic                  IF_ID_Write,
  input  logic                  Branch_taken,
  input  logic [PC_WIDTH-1:0]   Branch_target,
  output logic [PC_WIDTH-2:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata1,
  input  logic [INST_WIDTH-1:0] imem_rdata2,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] IF_ID_inst1,
  output logic [INST_WIDTH-1:0] IF_ID_inst2,
  output logic [PC_WIDTH-1:0]   IF_ID_pc,
  output logic                  IF_ID_valid1,
  output logic                  IF_ID_valid2
);

  typedef enum logic {StFill, StRun} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_next, pc_pair;
  logic                  redirect, bubble;
  logic [INST_WIDTH-1:0] inst1_q, inst1_d, inst2_q, inst2_d;
  logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic                  valid1_q, valid1_d, valid2_q, valid2_d;

  assign pc_pair  = {pc_q[PC_WIDTH-1:1], 1'b0};
  assign redirect = PCWrite & Branch_taken & (state_q == StRun);
  // A held PC would re-present the same pair, so IF/ID must take a bubble instead.
  assign bubble   = (state_q == StFill) | redirect | ~PCWrite;

  always_comb begin
    state_d = StRun;
    if (state_q == StFill) begin
      pc_next = pc_q;
    end else if (redirect) begin
      pc_next = Branch_target;
    end else if (PCWrite) begin
      pc_next = pc_pair + PC_WIDTH'(2);
    end else begin
      pc_next = pc_q;
    end
  end

  always_comb begin
    inst1_d  = inst1_q;
    inst2_d  = inst2_q;
    if_pc_d  = if_pc_q;
    valid1_d = valid1_q;
    valid2_d = valid2_q;
    if (IF_ID_Write) begin
      if (bubble) begin
        inst1_d  = '0;
        inst2_d  = '0;
        if_pc_d  = '0;
        valid1_d = 1'b0;
        valid2_d = 1'b0;
      end else begin
        inst1_d  = imem_rdata1;
        inst2_d  = imem_rdata2;
        if_pc_d  = pc_pair;
        // An odd PC lands mid-pair; the even-slot instruction precedes the target.
        valid1_d = ~pc_q[0];
        valid2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFill;
      pc_q     <= RESET_PC;
      inst1_q  <= '0;
      inst2_q  <= '0;
      if_pc_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_next;
      inst1_q  <= inst1_d;
      inst2_q  <= inst2_d;
      if_pc_q  <= if_pc_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign imem_addr    = pc_next[PC_WIDTH-1:1];
  assign pc           = pc_q;
  assign IF_ID_inst1  = inst1_q;
  assign IF_ID_inst2  = inst2_q;
  assign IF_ID_pc     = if_pc_q;
  assign IF_ID_valid1 = valid1_q;
  assign IF_ID_valid2 = valid2_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a synchronous pair memory where
// pair k holds {0x1000+2k, 0x1001+2k}.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_Write, Branch_taken;
  logic [7:0]  Branch_target;
  logic [6:0]  imem_addr;
  logic [15:0] imem_rdata1, imem_rdata2;
  logic [7:0]  pc, IF_ID_pc;
  logic [15:0] IF_ID_inst1, IF_ID_inst2;
  logic        IF_ID_valid1, IF_ID_valid2;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage #(.PC_WIDTH(8), .INST_WIDTH(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target), .imem_addr(imem_addr),
    .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2), .pc(pc),
    .IF_ID_inst1(IF_ID_inst1), .IF_ID_inst2(IF_ID_inst2), .IF_ID_pc(IF_ID_pc),
    .IF_ID_valid1(IF_ID_valid1), .IF_ID_valid2(IF_ID_valid2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata1 <= 16'h1000 + {8'h00, imem_addr, 1'b0};
    imem_rdata2 <= 16'h1001 + {8'h00, imem_addr, 1'b0};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1; Branch_taken = 1'b0;
    Branch_target = 8'h00;
    #2;
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, pc, IF_ID_pc, imem_addr} !== {2'b00, 8'h00, 8'h00, 7'h00})
      begin miscompares++; $display("FAIL reset_state got v=%b%b pc=%h ifpc=%h addr=%h want 00/00/00/00",
        IF_ID_valid1, IF_ID_valid2, pc, IF_ID_pc, imem_addr); end
    @(negedge clk); reset = 1'b1;
    step();
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, pc} !== {2'b00, 8'h00}) begin miscompares++;
      $display("FAIL fill_bubble got v=%b%b pc=%h want 00 pc=00", IF_ID_valid1, IF_ID_valid2, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_inst2, IF_ID_valid1, IF_ID_valid2, pc}
        !== {8'h00, 16'h1000, 16'h1001, 2'b11, 8'h02}) begin miscompares++;
      $display("FAIL first_pair got pc=%h i1=%h i2=%h v=%b%b pcq=%h want 00/1000/1001/11/02",
        IF_ID_pc, IF_ID_inst1, IF_ID_inst2, IF_ID_valid1, IF_ID_valid2, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1} !== {8'h02, 16'h1002}) begin miscompares++;
      $display("FAIL second_pair got pc=%h i1=%h want 02/1002", IF_ID_pc, IF_ID_inst1); end
  endtask

  task automatic test_stall();
    step();
    vectors++;
    if ({IF_ID_pc, pc} !== {8'h04, 8'h06}) begin miscompares++;
      $display("FAIL pre_stall got ifpc=%h pc=%h want 04/06", IF_ID_pc, pc); end
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    #1;
    vectors++;
    if (imem_addr !== 7'h03) begin miscompares++;
      $display("FAIL stall_addr got %h want 03", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({IF_ID_pc, pc, imem_addr, IF_ID_valid1, IF_ID_valid2} !== {8'h04, 8'h06, 7'h03, 2'b11})
        begin miscompares++; $display("FAIL stall_hold_%0d got ifpc=%h pc=%h addr=%h v=%b%b want 04/06/03/11",
          i, IF_ID_pc, pc, imem_addr, IF_ID_valid1, IF_ID_valid2); end
    end
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_inst2, IF_ID_valid1, IF_ID_valid2}
        !== {8'h06, 16'h1006, 16'h1007, 2'b11}) begin miscompares++;
      $display("FAIL post_stall got pc=%h i1=%h i2=%h v=%b%b want 06/1006/1007/11",
        IF_ID_pc, IF_ID_inst1, IF_ID_inst2, IF_ID_valid1, IF_ID_valid2); end
  endtask

  task automatic test_branch();
    step();
    vectors++;
    if (IF_ID_pc !== 8'h08) begin miscompares++;
      $display("FAIL pre_branch got ifpc=%h want 08", IF_ID_pc); end
    Branch_taken = 1'b1; Branch_target = 8'h20;
    #1;
    vectors++;
    if (imem_addr !== 7'h10) begin miscompares++;
      $display("FAIL branch_addr got %h want 10", imem_addr); end
    step();
    Branch_taken = 1'b0;
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, IF_ID_pc, pc} !== {2'b00, 8'h00, 8'h20}) begin miscompares++;
      $display("FAIL branch_bubble got v=%b%b ifpc=%h pc=%h want 00/00/20",
        IF_ID_valid1, IF_ID_valid2, IF_ID_pc, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2} !== {8'h20, 16'h1020, 2'b11})
      begin miscompares++; $display("FAIL branch_target got ifpc=%h i1=%h v=%b%b want 20/1020/11",
        IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2); end
  endtask

  task automatic test_odd_target();
    Branch_taken = 1'b1; Branch_target = 8'h21;
    step();
    Branch_taken = 1'b0;
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, pc} !== {2'b00, 8'h21}) begin miscompares++;
      $display("FAIL odd_bubble got v=%b%b pc=%h want 00/21", IF_ID_valid1, IF_ID_valid2, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_valid1, IF_ID_valid2, IF_ID_inst2, pc} !== {8'h20, 2'b01, 16'h1021, 8'h22})
      begin miscompares++; $display("FAIL odd_pair got ifpc=%h v=%b%b i2=%h pc=%h want 20/01/1021/22",
        IF_ID_pc, IF_ID_valid1, IF_ID_valid2, IF_ID_inst2, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2} !== {8'h22, 16'h1022, 2'b11})
      begin miscompares++; $display("FAIL odd_follow got ifpc=%h i1=%h v=%b%b want 22/1022/11",
        IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2); end
  endtask

  task automatic test_ignored_branch();
    PCWrite = 1'b0; IF_ID_Write = 1'b0; Branch_taken = 1'b1; Branch_target = 8'h50;
    step();
    vectors++;
    if ({pc, IF_ID_pc, IF_ID_valid1, IF_ID_valid2} !== {8'h24, 8'h22, 2'b11}) begin miscompares++;
      $display("FAIL stalled_branch_hold got pc=%h ifpc=%h v=%b%b want 24/22/11",
        pc, IF_ID_pc, IF_ID_valid1, IF_ID_valid2); end
    IF_ID_Write = 1'b1;
    step();
    vectors++;
    if ({pc, IF_ID_pc, IF_ID_valid1, IF_ID_valid2} !== {8'h24, 8'h00, 2'b00}) begin miscompares++;
      $display("FAIL stall_bubble got pc=%h ifpc=%h v=%b%b want 24/00/00",
        pc, IF_ID_pc, IF_ID_valid1, IF_ID_valid2); end
    PCWrite = 1'b1; Branch_taken = 1'b0;
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2, pc} !== {8'h24, 16'h1024, 2'b11, 8'h26})
      begin miscompares++; $display("FAIL no_lost_pair got ifpc=%h i1=%h v=%b%b pc=%h want 24/1024/11/26",
        IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2, pc); end
  endtask

  task automatic test_wrap();
    Branch_taken = 1'b1; Branch_target = 8'hFE;
    step();
    Branch_taken = 1'b0;
    #1;
    vectors++;
    if ({pc, imem_addr} !== {8'hFE, 7'h00}) begin miscompares++;
      $display("FAIL wrap_addr got pc=%h addr=%h want FE/00", pc, imem_addr); end
    step();
    vectors++;
    if ({pc, IF_ID_pc, IF_ID_inst1, IF_ID_inst2} !== {8'h00, 8'hFE, 16'h10FE, 16'h10FF})
      begin miscompares++; $display("FAIL wrap_pair got pc=%h ifpc=%h i1=%h i2=%h want 00/FE/10FE/10FF",
        pc, IF_ID_pc, IF_ID_inst1, IF_ID_inst2); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1} !== {8'h00, 16'h1000}) begin miscompares++;
      $display("FAIL wrap_follow got ifpc=%h i1=%h want 00/1000", IF_ID_pc, IF_ID_inst1); end
  endtask

  task automatic test_reset_midrun();
    step();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, pc, IF_ID_pc, imem_addr} !== {2'b00, 8'h00, 8'h00, 7'h00})
      begin miscompares++; $display("FAIL midrun_reset got v=%b%b pc=%h ifpc=%h addr=%h want 00/00/00/00",
        IF_ID_valid1, IF_ID_valid2, pc, IF_ID_pc, imem_addr); end
    @(negedge clk); reset = 1'b1;
    step();
    vectors++;
    if ({IF_ID_valid1, IF_ID_valid2, pc} !== {2'b00, 8'h00}) begin miscompares++;
      $display("FAIL refill_bubble got v=%b%b pc=%h want 00/00", IF_ID_valid1, IF_ID_valid2, pc); end
    step();
    vectors++;
    if ({IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2, pc} !== {8'h00, 16'h1000, 2'b11, 8'h02})
      begin miscompares++; $display("FAIL refill_pair got ifpc=%h i1=%h v=%b%b pc=%h want 00/1000/11/02",
        IF_ID_pc, IF_ID_inst1, IF_ID_valid1, IF_ID_valid2, pc); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_odd_target();
    test_ignored_branch();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
